dmem_serial_responder: RTL and testbench

- Memory-side responder for the Y86-64 data-memory interface; serves the rEn/wEn/address/data requests the memory stage issues.
- Backs a byte-wide RAM of MEM_BYTES bytes and serves each 64-bit access as 8 sequential byte transfers, one per cycle.
- Uses a valid/ready request handshake and a one-cycle response pulse carrying read data and an error flag.
- Sits between the memory-stage request logic and the byte RAM; replaces the single-cycle data memory when a multi-cycle memory model is wanted.

---
 rtl/dmem_serial_responder.sv | 147 ++++++++++++++
 tb/tb_dmem_serial_responder.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_serial_responder.sv
// dmem_serial_responder
//   Memory-side responder for the Y86-64 data-memory interface. Each 64-bit
//   access is served as eight sequential byte transfers against a byte-wide
//   RAM, so a good access completes eight cycles after it is accepted. Bytes
//   are little-endian: bits 8i+7:8i of the word live at address+i.
//
// Ports
//   clk         clock, all state changes on the rising edge
//   rst         synchronous active-high reset (RAM contents are kept)
//   req_valid   request present
//   req_ready   responder is idle and takes a request at this edge
//   req_ren     read request
//   req_wen     write request
//   req_addr    address of the lowest byte of the 8-byte word
//   req_wdata   write data
//   resp_valid  one-cycle response pulse
//   resp_rdata  read data (0 for writes and errors), meaningful with resp_valid
//   resp_err    error flag, meaningful with resp_valid
//   busy        a request is in flight
module dmem_serial_responder #(
  parameter int MEM_BYTES = 16384,
  parameter int ADDR_W    = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_ren,
  input  logic              req_wen,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [63:0]       req_wdata,
  output logic              resp_valid,
  output logic [63:0]       resp_rdata,
  output logic              resp_err,
  output logic              busy
);

  localparam int AW = $clog2(MEM_BYTES);
  // Highest legal start address of an 8-byte word.
  localparam logic [ADDR_W-1:0] LAST_START = ADDR_W'(MEM_BYTES - 8);

  typedef enum logic [1:0] {IDLE, XFER, RESP} stateT;

  stateT       stateReg, stateNext;
  logic [2:0]  cntReg;
  logic        renReg;
  logic        wenReg;
  logic        errReg;
  logic [AW-1:0] addrReg;
  logic [63:0] wdataReg;
  logic [63:0] accReg;

  logic        accept;
  logic        reqErr;
  logic        ramWe;
  logic        ramRe;
  logic [AW-1:0] ramAddr;

  logic [7:0]  mem [MEM_BYTES];

  // Full-width unsigned compare: addresses near 2^64 must not wrap into range.
  assign reqErr = (req_ren & req_wen) | (~req_ren & ~req_wen) |
                  (req_addr > LAST_START);
  assign accept = req_valid & req_ready;

  // Legal start addresses leave room for +7, so the low bits never overflow.
  assign ramAddr = addrReg + AW'(cntReg);
  // Writes are suppressed on a reset edge so an aborted access stops cleanly.
  assign ramWe   = (stateReg == XFER) & wenReg & ~rst;
  assign ramRe   = (stateReg == XFER) & renReg;

  always_comb begin
    stateNext  = stateReg;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    busy       = 1'b1;
    case (stateReg)
      IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) begin
          stateNext = reqErr ? RESP : XFER;
        end
      end
      XFER: begin
        if (cntReg == 3'd7) begin
          stateNext = RESP;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        stateNext  = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stateReg <= IDLE;
      cntReg   <= 3'd0;
      errReg   <= 1'b0;
      renReg   <= 1'b0;
      wenReg   <= 1'b0;
    end else begin
      stateReg <= stateNext;
      if (accept) begin
        cntReg <= 3'd0;
        errReg <= reqErr;
        renReg <= req_ren;
        wenReg <= req_wen;
      end else if (stateReg == XFER) begin
        cntReg <= cntReg + 3'd1;
      end
    end
  end

  // Request payload is only consumed while in XFER, so it needs no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      addrReg  <= req_addr[AW-1:0];
      wdataReg <= req_wdata;
    end
  end

  // Single synchronous RAM port; the registered read lands straight in the
  // accumulator byte selected by the counter. The accumulator doubles as the
  // response data, which is why it is cleared on every accept.
  always_ff @(posedge clk) begin
    if (ramWe) begin
      mem[ramAddr] <= wdataReg[{cntReg, 3'b000} +: 8];
    end
    if (rst) begin
      accReg <= 64'd0;
    end else if (accept) begin
      accReg <= 64'd0;
    end else if (ramRe) begin
      accReg[{cntReg, 3'b000} +: 8] <= mem[ramAddr];
    end
  end

  assign resp_rdata = accReg;
  assign resp_err   = errReg;

endmodule

// File: tb/tb_dmem_serial_responder.sv
module tb_dmem_serial_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_ren;
  logic        req_wen;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_err;
  logic        busy;

  always #5 clk = ~clk;

  dmem_serial_responder #(.MEM_BYTES(16384), .ADDR_W(64)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_ren    (req_ren),
    .req_wen    (req_wen),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .busy       (busy)
  );

  typedef struct {
    logic [63:0] rdata;
    logic        err;
    int          acceptCyc;
  } expT;

  expT        expQ[$];
  expT        monE;
  logic [7:0] model [16384];
  int         testsRun    = 0;
  int         testsFailed = 0;
  int         cyc         = 0;
  int         respCount   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    end
  endtask

  // Reference model: compute the expected response and update the byte model.
  task automatic pushExp(input logic ren, input logic wen, input logic [63:0] addr,
                         input logic [63:0] wdata);
    expT e;
    e.err       = (ren & wen) | (~ren & ~wen) | (addr > 64'd16376);
    e.rdata     = 64'd0;
    e.acceptCyc = cyc + 1;
    if (!e.err) begin
      for (int i = 0; i < 8; i++) begin
        if (ren) e.rdata[8*i +: 8] = model[int'(addr[13:0]) + i];
        if (wen) model[int'(addr[13:0]) + i] = wdata[8*i +: 8];
      end
    end
    expQ.push_back(e);
  endtask

  task automatic waitReady();
    int g = 0;
    @(negedge clk);
    while (!req_ready && g < 30) begin
      @(negedge clk);
      g++;
    end
    if (!req_ready) checkVal("ready_timeout", 64'(req_ready), 64'd1);
  endtask

  task automatic doReq(input logic ren, input logic wen, input logic [63:0] addr,
                       input logic [63:0] wdata);
    waitReady();
    req_valid = 1'b1;
    req_ren   = ren;
    req_wen   = wen;
    req_addr  = addr;
    req_wdata = wdata;
    pushExp(ren, wen, addr, wdata);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic waitDrain();
    int g = 0;
    while (expQ.size() != 0 && g < 30) begin
      @(negedge clk);
      g++;
    end
    if (expQ.size() != 0) begin
      checkVal("resp_timeout", 64'(expQ.size()), 64'd0);
      expQ.delete();
    end
  endtask

  // Scoreboard consumer: every response pulse is matched against the queue.
  always @(negedge clk) begin
    if (!rst && resp_valid) begin
      if (expQ.size() == 0) begin
        checkVal("unexpected_resp", 64'(resp_valid), 64'd0);
      end else begin
        monE = expQ.pop_front();
        respCount++;
        checkVal("rdata", resp_rdata, monE.rdata);
        checkVal("err", 64'(resp_err), 64'(monE.err));
        checkVal("latency", 64'(cyc - monE.acceptCyc), monE.err ? 64'd0 : 64'd8);
        $display("[TB] resp %0d: rdata=0x%016h err=%0d latency=%0d", respCount,
                 resp_rdata, resp_err, cyc - monE.acceptCyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int g;
    logic [63:0] a;
    logic [63:0] addrs [4];
    rst       = 1'b1;
    req_valid = 1'b0;
    req_ren   = 1'b0;
    req_wen   = 1'b0;
    req_addr  = 64'd0;
    req_wdata = 64'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checkVal("rst_ready", 64'(req_ready), 64'd1);
    checkVal("rst_busy", 64'(busy), 64'd0);
    checkVal("rst_resp_valid", 64'(resp_valid), 64'd0);
    checkVal("rst_rdata", resp_rdata, 64'd0);
    checkVal("rst_err", 64'(resp_err), 64'd0);

    // Basic write/read round trip.
    doReq(1'b0, 1'b1, 64'h100, 64'h1122334455667788); waitDrain();
    doReq(1'b1, 1'b0, 64'h100, 64'd0);                waitDrain();
    checkVal("ram_0x100", 64'(resp_rdata[7:0]), 64'h88);
    checkVal("ram_0x107", 64'(resp_rdata[63:56]), 64'h11);

    // Top of memory and just past it.
    doReq(1'b0, 1'b1, 64'd16376, 64'h0123456789ABCDEF); waitDrain();
    doReq(1'b1, 1'b0, 64'd16376, 64'd0);                waitDrain();
    doReq(1'b0, 1'b1, 64'd16377, 64'hFFFFFFFFFFFFFFFF); waitDrain();
    doReq(1'b1, 1'b0, 64'd16376, 64'd0);                waitDrain();
    doReq(1'b1, 1'b0, 64'hFFFFFFFFFFFFFFFC, 64'd0);     waitDrain();

    // Illegal command combinations must leave RAM untouched.
    doReq(1'b0, 1'b1, 64'h40, 64'h5555AAAA12345678);    waitDrain();
    doReq(1'b1, 1'b1, 64'h40, 64'hFFFFFFFFFFFFFFFF);    waitDrain();
    doReq(1'b0, 1'b0, 64'h40, 64'hFFFFFFFFFFFFFFFF);    waitDrain();
    doReq(1'b1, 1'b0, 64'h40, 64'd0);                   waitDrain();

    // Reset two bytes into a write.
    doReq(1'b0, 1'b1, 64'h200, 64'd0); waitDrain();
    waitReady();
    req_valid = 1'b1; req_ren = 1'b0; req_wen = 1'b1;
    req_addr  = 64'h200; req_wdata = 64'hAAAAAAAAAAAAAAAA;
    @(negedge clk); req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    checkVal("abort_busy", 64'(busy), 64'd0);
    checkVal("abort_ready", 64'(req_ready), 64'd1);
    checkVal("abort_resp_valid", 64'(resp_valid), 64'd0);
    model[16'h200] = 8'hAA;
    model[16'h201] = 8'hAA;
    doReq(1'b1, 1'b0, 64'h200, 64'd0); waitDrain();

    // Unaligned read spanning two written words.
    doReq(1'b0, 1'b1, 64'h308, 64'h0F0E0D0C0B0A0908); waitDrain();
    doReq(1'b0, 1'b1, 64'h300, 64'hDEADBEEF00000001); waitDrain();
    doReq(1'b1, 1'b0, 64'h304, 64'd0);                waitDrain();
    checkVal("rd_0x304", resp_rdata, 64'h0B0A0908DEADBEEF);

    // Back-to-back reads with req_valid held and req_addr changed mid-access.
    waitReady();
    req_valid = 1'b1; req_ren = 1'b1; req_wen = 1'b0; req_addr = 64'h100;
    pushExp(1'b1, 1'b0, 64'h100, 64'd0);
    @(negedge clk); req_addr = 64'h304;
    g = 0;
    while (!resp_valid && g < 20) begin
      @(negedge clk);
      g++;
    end
    checkVal("b2b_first_resp", 64'(resp_valid), 64'd1);
    @(negedge clk);
    checkVal("b2b_ready", 64'(req_ready), 64'd1);
    pushExp(1'b1, 1'b0, 64'h304, 64'd0);
    @(negedge clk); req_valid = 1'b0;
    waitDrain();

    // A few random word writes followed by readback.
    for (int i = 0; i < 4; i++) begin
      a = 64'h1000 + 64'(i * 16) + 64'($urandom_range(0, 7));
      addrs[i] = a;
      doReq(1'b0, 1'b1, a, {$urandom, $urandom}); waitDrain();
    end
    for (int i = 0; i < 4; i++) begin
      doReq(1'b1, 1'b0, addrs[i], 64'd0); waitDrain();
    end

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
